ysyx_22050612_mem_arbiter: RTL and testbench

YSYX_22050612_MEM_ARBITER -- requirements
Module: ysyx_22050612_mem_arbiter

---
 rtl/ysyx_22050612_pkg.sv | 20 ++
 rtl/ysyx_22050612_arb_pick.sv | 58 +++++
 rtl/ysyx_22050612_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_ysyx_22050612_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
//   state_e : arbiter FSM states (idle, request issued, waiting for response)
//   owner_e : which master owns the transaction in flight
package ysyx_22050612_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22050612_arb_pick.sv
// Grant selection between IFU and LSU with IFU starvation protection.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   en_i          : arbiter is able to accept a request this cycle
//   ifu_valid_i   : IFU request pending
//   lsu_valid_i   : LSU request pending
//   grant_ifu_o   : IFU wins this cycle (combinational)
//   grant_lsu_o   : LSU wins this cycle (combinational)
module ysyx_22050612_arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            starved;

  assign starved = (cnt_q == CntW'(STARVE_MAX));

  // LSU has priority unless IFU has already lost STARVE_MAX contested rounds.
  always_comb begin
    grant_ifu_o = 1'b0;
    grant_lsu_o = 1'b0;
    if (en_i) begin
      if (lsu_valid_i && !(ifu_valid_i && starved)) begin
        grant_lsu_o = 1'b1;
      end else if (ifu_valid_i) begin
        grant_ifu_o = 1'b1;
      end
    end
  end

  // Only contested LSU wins count as IFU losses; any IFU grant clears.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_ifu_o) begin
      cnt_d = '0;
    end else if (grant_lsu_o && ifu_valid_i && !starved) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-master (IFU, LSU) to single memory port arbiter, one transaction in flight.
//   clk, rst            : clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp : fetch request in, accept and response-valid out
//   lsu_req_* / lsu_rsp : load/store request in, accept and response-valid out
//   rsp_rdata           : read data returned to whichever master is responded to
//   mem_req_* / mem_*   : latched request toward memory, held until accepted
//   mem_rsp_valid/rdata : memory response
//   bus_err             : sticky flag for a response with no transaction to match
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                bus_err_q, bus_err_d;

  logic grant_ifu, grant_lsu;
  logic rsp_hit;
  logic stray;

  ysyx_22050612_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        ((state_q == StIdle) && !rst),
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  // A response completes the transaction in WAIT, or in REQ when accepted the
  // same cycle; anywhere else it has no owner and is flagged.
  assign rsp_hit = !rst && mem_rsp_valid &&
                   ((state_q == StWait) || ((state_q == StReq) && mem_req_ready));
  assign stray   = mem_rsp_valid &&
                   ((state_q == StIdle) || ((state_q == StReq) && !mem_req_ready));

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign ifu_rsp_valid = rsp_hit && (owner_q == OwnIfu);
  assign lsu_rsp_valid = rsp_hit && (owner_q == OwnLsu);
  assign rsp_rdata     = mem_rdata;
  assign mem_req_valid = (state_q == StReq) && !rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign bus_err       = bus_err_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    bus_err_d = bus_err_q | stray;
    unique case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          owner_d = OwnLsu;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          state_d = StReq;
        end else if (grant_ifu) begin
          owner_d = OwnIfu;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = mem_rsp_valid ? StIdle : StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnIfu;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
module tb_ysyx_22050612_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic [63:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic [63:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h0;
    lsu_req_valid = 1'b0;
    lsu_addr      = 64'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 64'h0;
    lsu_wmask     = 8'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'h0;
    step();
    #1;
    check_eq("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    step();
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    #1;
    check_eq("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_bus_err", 64'(bus_err), 64'd0);

    // Lone IFU fetch, ready at once, response one cycle later.
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0000;
    #1;
    check_eq("t1_ifu_ready", 64'(ifu_req_ready), 64'd1);
    check_eq("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check_eq("t1_mem_valid", 64'(mem_req_valid), 64'd1);
    check_eq("t1_mem_addr", mem_addr, 64'h8000_0000);
    check_eq("t1_mem_wen", 64'(mem_wen), 64'd0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0413;
    #1;
    check_eq("t1_ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    check_eq("t1_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    check_eq("t1_rdata", rsp_rdata, 64'h413);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("t1_rsp_once", 64'(ifu_rsp_valid), 64'd0);
    check_eq("t1_idle_mem", 64'(mem_req_valid), 64'd0);

    // Both valid: LSU store first, same-cycle ready+response, then IFU.
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_addr      = 64'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 64'hDEAD;
    lsu_wmask     = 8'hFF;
    #1;
    check_eq("t2_lsu_ready", 64'(lsu_req_ready), 64'd1);
    check_eq("t2_ifu_ready", 64'(ifu_req_ready), 64'd0);
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h1234;
    #1;
    check_eq("t2_mem_addr", mem_addr, 64'h8000_1000);
    check_eq("t2_mem_wdata", mem_wdata, 64'hDEAD);
    check_eq("t2_mem_wmask", 64'(mem_wmask), 64'hFF);
    check_eq("t2_mem_wen", 64'(mem_wen), 64'd1);
    check_eq("t2_lsu_rsp", 64'(lsu_rsp_valid), 64'd1);
    check_eq("t2_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    check_eq("t2_busy_ready", 64'(ifu_req_ready), 64'd0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("t2_ifu_next", 64'(ifu_req_ready), 64'd1);
    step();
    ifu_req_valid = 1'b0;
    #1;
    check_eq("t2_ifu_addr", mem_addr, 64'h8000_0004);
    check_eq("t2_ifu_wen", 64'(mem_wen), 64'd0);
    check_eq("t2_ifu_wdata", mem_wdata, 64'd0);
    check_eq("t2_ifu_wmask", 64'(mem_wmask), 64'd0);

    // Memory stalls for 5 cycles in REQ with both masters asking.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_mem_valid", 64'(mem_req_valid), 64'd1);
      check_eq("t3_mem_addr", mem_addr, 64'h8000_0004);
      check_eq("t3_mem_wdata", mem_wdata, 64'd0);
      check_eq("t3_ifu_ready", 64'(ifu_req_ready), 64'd0);
      check_eq("t3_lsu_ready", 64'(lsu_req_ready), 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h55;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    check_eq("t3_ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    check_eq("t3_rdata", rsp_rdata, 64'h55);
    step();
    mem_rsp_valid = 1'b0;

    // Both held valid: four LSU wins, then IFU, then LSU again.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("t4_ifu_grant", 64'(ifu_req_ready), (i == 4) ? 64'd1 : 64'd0);
      check_eq("t4_lsu_grant", 64'(lsu_req_ready), (i == 4) ? 64'd0 : 64'd1);
      step();
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      #1;
      check_eq("t4_owner_rsp", 64'(ifu_rsp_valid), (i == 4) ? 64'd1 : 64'd0);
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    check_eq("t4_bus_err", 64'(bus_err), 64'd0);

    // Stray response in IDLE sets sticky bus_err; reset clears it.
    mem_rsp_valid = 1'b1;
    #1;
    check_eq("t5_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    check_eq("t5_lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("t5_bus_err", 64'(bus_err), 64'd1);
    step();
    step();
    check_eq("t5_bus_err_sticky", 64'(bus_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("t5_bus_err_rst", 64'(bus_err), 64'd0);

    // Reset while waiting aborts; the late response is then a stray.
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0100;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    #1;
    check_eq("t6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("t6_idle_mem_valid", 64'(mem_req_valid), 64'd0);
    check_eq("t6_idle_addr", mem_addr, 64'd0);
    mem_rsp_valid = 1'b1;
    #1;
    check_eq("t6_late_ifu_rsp", 64'(ifu_rsp_valid), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("t6_late_bus_err", 64'(bus_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
